pc_return_stack: RTL and testbench
==================================

// Module: pc_return_stack
// PURPOSE
//  Return-address LIFO for the multicycle CPU; the reverse path of the PC incrementer.
//  On a call, control pushes the incremented PC (PC+1). On a return, it pops that value back into the PC mux.
//  Sits between the PC register/increment path and the PC-source mux.
//  Written as a circular buffer: overflow overwrites the oldest entry. It never stalls.
// PARAMETERS
//  WIDTH  32  address width in bits
//  DEPTH  8   number of entries; power of two, >= 2
//  AW     3   pointer width; must equal log2(DEPTH)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  push       in   1      push push_addr this cycle
//  push_addr  in   WIDTH  return address to save (PC+1)
//  pop        in   1      pop top entry this cycle
//  top_addr   out  WIDTH  current top of stack; combinational read of a registered entry
//  empty      out  1      count == 0
//  full       out  1      count == DEPTH
//  count      out  AW+1   number of valid entries, 0..DEPTH
//  overflow   out  1      sticky: a push occurred while full
//  underflow  out  1      sticky: a pop occurred while empty
//  clr_err    in   1      synchronous clear of overflow/underflow
// BEHAVIOUR
//  Storage: mem[DEPTH] plus pointer tp, which is the index of the next free slot.
//  top_addr = mem[tp-1] mod DEPTH. Pointer arithmetic wraps modulo DEPTH.
//  Reset (async, rst=1):
//   tp=0, count=0, overflow=0, underflow=0, so empty=1 and full=0.
//   top_addr=0: all mem entries are cleared to 0.
//  All updates take effect on the rising edge. Outputs reflect the update one cycle later; no extra latency.
//  push only, not full:
//   mem[tp] <= push_addr; tp <= tp+1; count <= count+1.
//  push only, full:
//   Same write; tp wraps, so the oldest entry is overwritten.
//   count stays DEPTH. overflow <= 1.
//  pop only, not empty:
//   tp <= tp-1; count <= count-1.
//   top_addr must be sampled by the consumer in the same cycle pop is high.
//  pop only, empty:
//   No state change except underflow <= 1. top_addr holds its value.
//  push and pop together, not empty:
//   Replace the top: mem[tp-1] <= push_addr. tp and count are unchanged (tail-call case).
//  push and pop together, empty:
//   Treated as push only: mem[tp] <= push_addr; tp <= tp+1; count <= 1.
//   underflow <= 1.
//  clr_err: clears both sticky flags.
//   If a new error event occurs in the same cycle, the set wins.
//  Neither push nor pop: hold all state.
//  rst mid-operation: immediate async clear. Any push or pop in that cycle is discarded.
// TESTING
//  1. Reset, then push 0x10, 0x20, 0x30 -> count=3 and top_addr=0x30. Pop x3 -> top reads 0x30, 0x20, 0x10; then empty=1.
//  2. Push 9 values 1..9 with DEPTH=8 -> full=1, overflow=1, count=8. Pop x8 -> reads 9,8,...,2; then empty=1.
//  3. Pop while empty -> underflow=1, count=0. clr_err -> underflow=0. clr_err with a simultaneous empty pop -> underflow stays 1.
//  4. count=2 with top 0x44; push 0x55 and pop together -> count=2, top_addr=0x55. Pop -> the prior entry returns.
//  5. count=5; assert rst asynchronously mid-cycle together with push -> count=0, empty=1 and top_addr=0 immediately; no write.
//  6. Random push/pop for 10k cycles against a reference queue model -> top_addr, count and flags match every cycle.

Source files
------------

// File: rtl/pc_return_stack.sv
// Return-address LIFO for the multicycle CPU.
// Circular buffer: a push while full overwrites the oldest entry, so the
// stack never stalls. Overflow/underflow are sticky until clr_err.
module pc_return_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             pop,
    output logic [WIDTH-1:0] top_addr,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    tp_q, tp_d;
    logic [AW-1:0]    top_idx;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             set_ovf, set_unf;

    // tp is the next free slot, so the top lives one below it (wrapping).
    assign top_idx   = tp_q - PTR_ONE;
    assign top_addr  = mem_q[top_idx];
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Next-state: push/pop/replace-top and sticky error flags.
    always_comb begin
        mem_d   = mem_q;
        tp_d    = tp_q;
        count_d = count_q;

        if (push && pop && !empty) begin
            // Tail call: replace the top in place.
            mem_d[top_idx] = push_addr;
        end else if (push) begin
            // Also covers push+pop on an empty stack.
            mem_d[tp_q] = push_addr;
            tp_d        = tp_q + PTR_ONE;
            if (!full) begin
                count_d = count_q + CNT_ONE;
            end
        end else if (pop && !empty) begin
            tp_d    = tp_q - PTR_ONE;
            count_d = count_q - CNT_ONE;
        end

        set_ovf = push && !pop && full;
        set_unf = pop && empty;

        // A new error in the same cycle as clr_err keeps the flag set.
        overflow_d  = (overflow_q  && !clr_err) || set_ovf;
        underflow_d = (underflow_q && !clr_err) || set_unf;
    end

    // State registers; reset also clears storage so top_addr reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            tp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            tp_q        <= tp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_pc_return_stack.sv
// Bench for pc_return_stack: a queue-based reference model produces the
// expected register state each cycle; a negedge monitor compares it.
module tb_pc_return_stack;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0;
    logic [WIDTH-1:0] push_addr = '0;
    logic             pop = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] top_addr;
    logic             empty, full, overflow, underflow;
    logic [AW:0]      count;

    pc_return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (push_addr),
        .pop       (pop),
        .top_addr  (top_addr),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] top;
        bit               chk_top;
        logic [AW:0]      cnt;
        bit               emp;
        bit               ful;
        bit               ovf;
        bit               unf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: queue of valid entries, oldest at the front.
    logic [WIDTH-1:0] mq[$];
    bit               m_ovf = 0;
    bit               m_unf = 0;
    bit               zero_known = 1;

    function automatic void chk(input string nm, input string fld,
                                input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
        end
    endfunction

    function automatic void enq(input string nm);
        exp_t e;
        e.name    = nm;
        e.top     = (mq.size() > 0) ? mq[mq.size()-1] : '0;
        e.chk_top = (mq.size() > 0) || zero_known;
        e.cnt     = (AW+1)'(mq.size());
        e.emp     = (mq.size() == 0);
        e.ful     = (mq.size() == DEPTH);
        e.ovf     = m_ovf;
        e.unf     = m_unf;
        exp_q.push_back(e);
    endfunction

    // Monitor: every expectation queued before this edge is compared now.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk_top) chk(e.name, "top_addr", top_addr, e.top);
            chk(e.name, "count",     WIDTH'(count),     WIDTH'(e.cnt));
            chk(e.name, "empty",     WIDTH'(empty),     WIDTH'(e.emp));
            chk(e.name, "full",      WIDTH'(full),      WIDTH'(e.ful));
            chk(e.name, "overflow",  WIDTH'(overflow),  WIDTH'(e.ovf));
            chk(e.name, "underflow", WIDTH'(underflow), WIDTH'(e.unf));
        end
    end

    // One clock of stimulus: queue the current expected state, advance model.
    task automatic step(input bit p, input logic [WIDTH-1:0] a, input bit po,
                        input bit c, input string nm);
        bit was_empty;
        bit was_full;
        push      = p;
        push_addr = a;
        pop       = po;
        clr_err   = c;
        enq(nm);
        was_empty = (mq.size() == 0);
        was_full  = (mq.size() == DEPTH);
        if (p && po && !was_empty) begin
            mq[mq.size()-1] = a;
        end else if (p) begin
            if (was_full) void'(mq.pop_front());
            mq.push_back(a);
        end else if (po && !was_empty) begin
            void'(mq.pop_back());
        end
        if (c) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (p && !po && was_full) m_ovf = 1;
        if (po && was_empty) m_unf = 1;
        if (p) zero_known = 0;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf      = 0;
        m_unf      = 0;
        zero_known = 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        do_reset();
        step(0, '0, 0, 0, "reset_state");

        // 1: basic LIFO order
        step(1, 32'h10, 0, 0, "t1_push10");
        step(1, 32'h20, 0, 0, "t1_push20");
        step(1, 32'h30, 0, 0, "t1_push30");
        step(0, '0, 1, 0, "t1_pop30");
        step(0, '0, 1, 0, "t1_pop20");
        step(0, '0, 1, 0, "t1_pop10");
        step(0, '0, 0, 0, "t1_empty");

        // 2: overflow overwrites oldest
        do_reset();
        for (int i = 1; i <= 9; i++) step(1, WIDTH'(i), 0, 0, $sformatf("t2_push%0d", i));
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0, $sformatf("t2_pop%0d", i));
        step(0, '0, 0, 0, "t2_empty");

        // 3: underflow and clear priority
        do_reset();
        step(0, '0, 1, 0, "t3_pop_empty");
        step(0, '0, 0, 1, "t3_unf_set");
        step(0, '0, 1, 1, "t3_unf_cleared");
        step(0, '0, 0, 0, "t3_set_wins");

        // 4: tail-call replace
        do_reset();
        step(1, 32'h33, 0, 0, "t4_push33");
        step(1, 32'h44, 0, 0, "t4_push44");
        step(1, 32'h55, 1, 0, "t4_replace");
        step(0, '0, 1, 0, "t4_pop55");
        step(0, '0, 0, 0, "t4_prior");
        step(1, 32'h66, 1, 0, "t4_pushpop");
        step(1, 32'h77, 1, 0, "t4_replace2");
        step(0, '0, 0, 0, "t4_after");
        step(0, '0, 1, 0, "t4_pop_last");
        step(1, 32'h88, 1, 0, "t4_pushpop_empty");
        step(0, '0, 0, 0, "t4_pp_empty_res");

        // 5: async reset mid-cycle together with a push
        do_reset();
        for (int i = 0; i < 5; i++) step(1, WIDTH'(32'hA0 + i), 0, 0, "t5_fill");
        step(0, '0, 1, 0, "t5_count5");
        step(0, '0, 0, 0, "t5_count4");
        step(1, 32'hB0, 0, 0, "t5_count4b");
        push      = 1'b1;
        push_addr = 32'hDEAD;
        #2;
        rst = 1'b1;
        model_reset();
        enq("t5_async_rst");
        @(posedge clk);
        #1;
        rst  = 1'b0;
        push = 1'b0;
        step(0, '0, 0, 0, "t5_no_write");
        step(0, '0, 1, 0, "t5_pop_after");

        // 6: random traffic against the model
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), "t6_rand");
        end
        step(0, '0, 0, 0, "t6_final");

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
